// File: rtl/tilelink_ul_master_adapter.sv
// Single-outstanding TL-UL master: turns a one-word bus request into an A-channel
// message, checks the matching D-channel response and bounds the wait with a timeout.
module tilelink_ul_master_adapter #(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [TL_ADDR_WIDTH-1:0]   req_addr,
    input  logic [TL_DATA_WIDTH-1:0]   req_wdata,
    input  logic [TL_STRB_WIDTH-1:0]   req_be,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [TL_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                       rsp_error,
    output logic                       rsp_timeout,
    output logic                       a_valid,
    input  logic                       a_ready,
    output logic [TL_OPCODE_WIDTH-1:0] a_opcode,
    output logic [TL_PARAM_WIDTH-1:0]  a_param,
    output logic [TL_ADDR_WIDTH-1:0]   a_address,
    output logic [TL_SIZE_WIDTH-1:0]   a_size,
    output logic [TL_STRB_WIDTH-1:0]   a_mask,
    output logic [TL_DATA_WIDTH-1:0]   a_data,
    output logic [TL_SOURCE_WIDTH-1:0] a_source,
    input  logic                       d_valid,
    output logic                       d_ready,
    input  logic [TL_OPCODE_WIDTH-1:0] d_opcode,
    input  logic [TL_PARAM_WIDTH-1:0]  d_param,
    input  logic [TL_SIZE_WIDTH-1:0]   d_size,
    input  logic [TL_SINK_WIDTH-1:0]   d_sink,
    input  logic [TL_SOURCE_WIDTH-1:0] d_source,
    input  logic [TL_DATA_WIDTH-1:0]   d_data,
    input  logic                       d_error
);

    localparam int OFF_W = $clog2(TL_STRB_WIDTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TL_OPCODE_WIDTH-1:0] OPC_PUT_FULL    = TL_OPCODE_WIDTH'(0);
    localparam logic [TL_OPCODE_WIDTH-1:0] OPC_PUT_PARTIAL = TL_OPCODE_WIDTH'(1);
    localparam logic [TL_OPCODE_WIDTH-1:0] OPC_GET         = TL_OPCODE_WIDTH'(4);
    localparam logic [TL_OPCODE_WIDTH-1:0] OPC_ACK         = TL_OPCODE_WIDTH'(0);
    localparam logic [TL_OPCODE_WIDTH-1:0] OPC_ACK_DATA    = TL_OPCODE_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, A_SEND, WAIT_D, RSP} state_t;

    state_t                       state, state_next;
    logic [TL_SOURCE_WIDTH-1:0]   src_cnt;
    logic [TMO_W-1:0]             tmo_cnt;
    logic                         misaligned;
    logic                         tmo_hit;
    logic                         is_get;
    logic [TL_OPCODE_WIDTH-1:0]   exp_d_opcode;
    logic                         d_bad;
    logic                         unused_d_fields;

    assign misaligned   = (req_addr[OFF_W-1:0] != '0);
    assign tmo_hit      = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign is_get       = (a_opcode == OPC_GET);
    assign exp_d_opcode = is_get ? OPC_ACK_DATA : OPC_ACK;
    assign d_bad        = d_error || (d_source != a_source) || (d_opcode != exp_d_opcode);

    // Response sideband fields carry nothing this single-word master needs.
    assign unused_d_fields = ^{d_param, d_size, d_sink};

    assign req_ready = (state == IDLE);
    assign a_valid   = (state == A_SEND);
    assign d_ready   = (state == WAIT_D);
    assign rsp_valid = (state == RSP);
    assign a_param   = '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = misaligned ? RSP : A_SEND;
            A_SEND:  if (a_ready) state_next = WAIT_D;
            WAIT_D:  if (d_valid || tmo_hit) state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every register below uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_opcode    <= '0;
            a_address   <= '0;
            a_size      <= '0;
            a_mask      <= '0;
            a_data      <= '0;
            a_source    <= '0;
            src_cnt     <= '0;
            tmo_cnt     <= '0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    a_opcode  <= !req_we ? OPC_GET : ((&req_be) ? OPC_PUT_FULL : OPC_PUT_PARTIAL);
                    a_address <= req_addr;
                    a_size    <= TL_SIZE_WIDTH'(OFF_W);
                    a_mask    <= req_we ? req_be : '1;
                    a_data    <= req_we ? req_wdata : '0;
                    a_source  <= src_cnt;
                    // A misaligned request completes locally and never consumes a source ID.
                    if (misaligned) begin
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= '0;
                    end
                end
                A_SEND: if (a_ready) begin
                    src_cnt <= src_cnt + 1'b1;
                    tmo_cnt <= '0;
                end
                WAIT_D: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (d_valid) begin
                        rsp_error   <= d_bad;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (is_get && !d_bad) ? d_data : '0;
                    end else if (tmo_hit) begin
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end
                end
                RSP: if (rsp_ready) begin
                    rsp_error   <= 1'b0;
                    rsp_timeout <= 1'b0;
                    rsp_rdata   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tilelink_ul_master_adapter.sv
// Directed bench for tilelink_ul_master_adapter: hand-computed A-channel fields,
// response checking, timeout boundary, back-pressure and mid-transaction reset.
module tb_tilelink_ul_master_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [7:0]  req_be = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_error, rsp_timeout;
    logic        a_valid, a_ready = 1'b0;
    logic [2:0]  a_opcode, a_param, a_source;
    logic [63:0] a_address, a_data;
    logic [7:0]  a_size, a_mask;
    logic        d_valid = 1'b0, d_ready, d_error = 1'b0;
    logic [2:0]  d_opcode = '0, d_param = '0, d_sink = '0, d_source = '0;
    logic [7:0]  d_size = '0;
    logic [63:0] d_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tilelink_ul_master_adapter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_address(a_address), .a_size(a_size), .a_mask(a_mask), .a_data(a_data),
        .a_source(a_source),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_sink(d_sink), .d_source(d_source), .d_data(d_data),
        .d_error(d_error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req_ready"},   64'(req_ready),   64'h1);
        check({tag, ".a_valid"},     64'(a_valid),     64'h0);
        check({tag, ".a_opcode"},    64'(a_opcode),    64'h0);
        check({tag, ".a_param"},     64'(a_param),     64'h0);
        check({tag, ".a_address"},   a_address,        64'h0);
        check({tag, ".a_size"},      64'(a_size),      64'h0);
        check({tag, ".a_mask"},      64'(a_mask),      64'h0);
        check({tag, ".a_data"},      a_data,           64'h0);
        check({tag, ".a_source"},    64'(a_source),    64'h0);
        check({tag, ".d_ready"},     64'(d_ready),     64'h0);
        check({tag, ".rsp_valid"},   64'(rsp_valid),   64'h0);
        check({tag, ".rsp_rdata"},   rsp_rdata,        64'h0);
        check({tag, ".rsp_error"},   64'(rsp_error),   64'h0);
        check({tag, ".rsp_timeout"}, 64'(rsp_timeout), 64'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #2;
        check_reset_outputs(tag);
        step();
        rst = 1'b1;
    endtask

    task automatic send_req(input string tag, input logic [63:0] we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] be);
        check({tag, ".req_ready"}, 64'(req_ready), 64'h1);
        req_valid = 1'b1;
        req_we    = we[0];
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be[7:0];
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    task automatic check_a(input string tag, input logic [63:0] opc, input logic [63:0] addr,
                           input logic [63:0] mask, input logic [63:0] data, input logic [63:0] src);
        check({tag, ".a_valid"},   64'(a_valid),   64'h1);
        check({tag, ".a_opcode"},  64'(a_opcode),  opc);
        check({tag, ".a_param"},   64'(a_param),   64'h0);
        check({tag, ".a_address"}, a_address,      addr);
        check({tag, ".a_size"},    64'(a_size),    64'h3);
        check({tag, ".a_mask"},    64'(a_mask),    mask);
        check({tag, ".a_data"},    a_data,         data);
        check({tag, ".a_source"},  64'(a_source),  src);
        check({tag, ".req_ready"}, 64'(req_ready), 64'h0);
    endtask

    task automatic a_hs(input string tag);
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        check({tag, ".a_valid_drop"}, 64'(a_valid), 64'h0);
        check({tag, ".d_ready"},      64'(d_ready), 64'h1);
    endtask

    task automatic d_resp(input logic [63:0] opc, input logic [63:0] src,
                          input logic [63:0] data, input logic [63:0] err);
        d_valid  = 1'b1;
        d_opcode = opc[2:0];
        d_source = src[2:0];
        d_data   = data;
        d_error  = err[0];
        d_size   = 8'd3;
        step();
        d_valid  = 1'b0;
        d_opcode = '0;
        d_source = '0;
        d_data   = '0;
        d_error  = 1'b0;
        d_size   = '0;
    endtask

    task automatic check_rsp(input string tag, input logic [63:0] err, input logic [63:0] tmo,
                             input logic [63:0] rdata);
        check({tag, ".rsp_valid"},   64'(rsp_valid),   64'h1);
        check({tag, ".rsp_error"},   64'(rsp_error),   err);
        check({tag, ".rsp_timeout"}, 64'(rsp_timeout), tmo);
        check({tag, ".rsp_rdata"},   rsp_rdata,        rdata);
        check({tag, ".d_ready"},     64'(d_ready),     64'h0);
    endtask

    task automatic rsp_hs(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, ".rsp_valid_drop"}, 64'(rsp_valid),   64'h0);
        check({tag, ".req_ready_back"}, 64'(req_ready),   64'h1);
        check({tag, ".rsp_error_clr"},  64'(rsp_error),   64'h0);
        check({tag, ".rsp_tmo_clr"},    64'(rsp_timeout), 64'h0);
    endtask

    initial begin
        #3;
        check_reset_outputs("por");
        step();
        rst = 1'b1;
        step();

        // Aligned read: Get, full mask, source 0.
        send_req("rd40", 64'h0, 64'h40, 64'h0, 64'h0);
        check_a("rd40", 64'h4, 64'h40, 64'hFF, 64'h0, 64'h0);
        a_hs("rd40");
        d_resp(64'h1, 64'h0, 64'hDEAD_BEEF_0000_0001, 64'h0);
        check_rsp("rd40", 64'h0, 64'h0, 64'hDEAD_BEEF_0000_0001);
        rsp_hs("rd40");

        // Full then partial write, sources 0 and 1 after reset.
        do_reset("rst1");
        send_req("wrff", 64'h1, 64'h08, 64'h1111_2222_3333_4444, 64'hFF);
        check_a("wrff", 64'h0, 64'h08, 64'hFF, 64'h1111_2222_3333_4444, 64'h0);
        a_hs("wrff");
        d_resp(64'h0, 64'h0, 64'h0, 64'h0);
        check_rsp("wrff", 64'h0, 64'h0, 64'h0);
        rsp_hs("wrff");
        send_req("wr0f", 64'h1, 64'h08, 64'h5555_6666_7777_8888, 64'h0F);
        check_a("wr0f", 64'h1, 64'h08, 64'h0F, 64'h5555_6666_7777_8888, 64'h1);
        a_hs("wr0f");
        d_resp(64'h0, 64'h1, 64'h0, 64'h0);
        check_rsp("wr0f", 64'h0, 64'h0, 64'h0);
        rsp_hs("wr0f");

        // Misaligned read completes locally and leaves the source counter alone.
        do_reset("rst2");
        send_req("mis43", 64'h0, 64'h43, 64'h0, 64'h0);
        check("mis43.a_valid", 64'(a_valid), 64'h0);
        check_rsp("mis43", 64'h1, 64'h0, 64'h0);
        rsp_hs("mis43");
        check("mis43.a_valid_after", 64'(a_valid), 64'h0);

        send_req("rd10", 64'h0, 64'h10, 64'h0, 64'h0);
        check_a("rd10", 64'h4, 64'h10, 64'hFF, 64'h0, 64'h0);
        a_hs("rd10");
        d_resp(64'h1, 64'h0, 64'h0000_0000_0000_1234, 64'h0);
        check_rsp("rd10", 64'h0, 64'h0, 64'h0000_0000_0000_1234);
        rsp_hs("rd10");

        // Wrong opcode for a Get.
        send_req("rd18", 64'h0, 64'h18, 64'h0, 64'h0);
        check_a("rd18", 64'h4, 64'h18, 64'hFF, 64'h0, 64'h1);
        a_hs("rd18");
        d_resp(64'h0, 64'h1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0);
        check_rsp("rd18_badopc", 64'h1, 64'h0, 64'h0);
        rsp_hs("rd18");

        // Wrong source: 2 issued, 5 returned.
        send_req("rd20", 64'h0, 64'h20, 64'h0, 64'h0);
        check_a("rd20", 64'h4, 64'h20, 64'hFF, 64'h0, 64'h2);
        a_hs("rd20");
        d_resp(64'h1, 64'h5, 64'hBBBB_BBBB_BBBB_BBBB, 64'h0);
        check_rsp("rd20_badsrc", 64'h1, 64'h0, 64'h0);
        rsp_hs("rd20");

        // Slave-reported error on a write.
        send_req("wr28", 64'h1, 64'h28, 64'h0000_0000_CAFE_F00D, 64'hF0);
        check_a("wr28", 64'h1, 64'h28, 64'hF0, 64'h0000_0000_CAFE_F00D, 64'h3);
        a_hs("wr28");
        d_resp(64'h0, 64'h3, 64'h0, 64'h1);
        check_rsp("wr28_derr", 64'h1, 64'h0, 64'h0);
        rsp_hs("wr28");

        // Timeout: no D response, rsp_valid 8 cycles after entering WAIT_D.
        send_req("tmo", 64'h0, 64'h30, 64'h0, 64'h0);
        check_a("tmo", 64'h4, 64'h30, 64'hFF, 64'h0, 64'h4);
        a_hs("tmo");
        for (int i = 0; i < 7; i++) begin
            check("tmo.wait_rsp_valid", 64'(rsp_valid), 64'h0);
            step();
        end
        check("tmo.last_wait_rsp_valid", 64'(rsp_valid), 64'h0);
        check("tmo.last_wait_d_ready", 64'(d_ready), 64'h1);
        step();
        check_rsp("tmo", 64'h1, 64'h1, 64'h0);
        rsp_hs("tmo");
        // Stray D beat in IDLE must be ignored.
        check("stray.d_ready", 64'(d_ready), 64'h0);
        d_resp(64'h1, 64'h4, 64'h1234, 64'h0);
        check("stray.rsp_valid", 64'(rsp_valid), 64'h0);
        check("stray.req_ready", 64'(req_ready), 64'h1);
        check("stray.a_valid", 64'(a_valid), 64'h0);

        // Response arriving on the last timeout cycle wins.
        send_req("edge", 64'h0, 64'h38, 64'h0, 64'h0);
        check_a("edge", 64'h4, 64'h38, 64'hFF, 64'h0, 64'h5);
        a_hs("edge");
        for (int i = 0; i < 7; i++) step();
        check("edge.rsp_valid", 64'(rsp_valid), 64'h0);
        d_resp(64'h1, 64'h5, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0);
        check_rsp("edge", 64'h0, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F);
        rsp_hs("edge");

        // A-channel back-pressure for 5 cycles, then response held for 3.
        send_req("stall", 64'h1, 64'h48, 64'h0102_0304_0506_0708, 64'h3C);
        for (int i = 0; i < 5; i++) begin
            check_a("stall", 64'h1, 64'h48, 64'h3C, 64'h0102_0304_0506_0708, 64'h6);
            step();
        end
        check_a("stall_end", 64'h1, 64'h48, 64'h3C, 64'h0102_0304_0506_0708, 64'h6);
        a_hs("stall");
        d_resp(64'h0, 64'h6, 64'h0, 64'h1);
        for (int i = 0; i < 3; i++) begin
            check_rsp("hold", 64'h1, 64'h0, 64'h0);
            step();
        end
        check_rsp("hold_end", 64'h1, 64'h0, 64'h0);
        rsp_hs("hold");

        // Reset pulse while waiting on D, then the source counter restarts at 0.
        send_req("mid", 64'h0, 64'h50, 64'h0, 64'h0);
        check_a("mid", 64'h4, 64'h50, 64'hFF, 64'h0, 64'h7);
        a_hs("mid");
        step();
        do_reset("rst_mid");
        step();
        check("post_rst.rsp_valid", 64'(rsp_valid), 64'h0);
        send_req("post", 64'h0, 64'h58, 64'h0, 64'h0);
        check_a("post", 64'h4, 64'h58, 64'hFF, 64'h0, 64'h0);
        a_hs("post");
        d_resp(64'h1, 64'h0, 64'h7777_0000_7777_0000, 64'h0);
        check_rsp("post", 64'h0, 64'h0, 64'h7777_0000_7777_0000);
        rsp_hs("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tilelink_ul_master_adapter.md
Name: tilelink_ul_master_adapter

Overview:
Upstream neighbour of the TL-UL slave (tilelink_ul_slave_top). Converts a simple single-word CPU/peripheral-bus request into a TL-UL A-channel message and collects the matching D-channel response.
Supports one outstanding transaction. Source IDs rotate per transaction, and each D response is checked against the expected source and opcode. A response timeout guarantees forward progress.

Parameters:
TL_ADDR_WIDTH, 64, address width
TL_DATA_WIDTH, 64, data width
TL_STRB_WIDTH, TL_DATA_WIDTH/8, byte-mask width
TL_SOURCE_WIDTH, 3, source ID width
TL_SINK_WIDTH, 3, sink ID width
TL_OPCODE_WIDTH, 3, opcode width
TL_PARAM_WIDTH, 3, param width
TL_SIZE_WIDTH, 8, size field width
TIMEOUT_CYCLES, 256, maximum cycles spent in WAIT_D before forced error completion (must be >= 1)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, reset is asynchronous and active-low
req_valid  in  1  request valid
req_ready  out  1  adapter can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  TL_ADDR_WIDTH  byte address
req_wdata  in  TL_DATA_WIDTH  write data
req_be  in  TL_STRB_WIDTH  byte enables for writes
rsp_valid  out  1  response valid
rsp_ready  in  1  requester accepts response
rsp_rdata  out  TL_DATA_WIDTH  read data (0 for writes and errors)
rsp_error  out  1  response carries an error
rsp_timeout  out  1  error was caused by timeout
a_valid  out  1  TL-UL A channel
a_ready  in  1
a_opcode  out  TL_OPCODE_WIDTH
a_param  out  TL_PARAM_WIDTH
a_address  out  TL_ADDR_WIDTH
a_size  out  TL_SIZE_WIDTH
a_mask  out  TL_STRB_WIDTH
a_data  out  TL_DATA_WIDTH
a_source  out  TL_SOURCE_WIDTH
d_valid  in  1  TL-UL D channel
d_ready  out  1
d_opcode  in  TL_OPCODE_WIDTH
d_param  in  TL_PARAM_WIDTH
d_size  in  TL_SIZE_WIDTH
d_sink  in  TL_SINK_WIDTH
d_source  in  TL_SOURCE_WIDTH
d_data  in  TL_DATA_WIDTH
d_error  in  1

Behaviour:
- Opcodes: PutFullData=0, PutPartialData=1, Get=4; AccessAck=0, AccessAckData=1.
- Reset (rst low, async): state IDLE; all outputs 0 except req_ready=1; source counter 0; timeout counter 0.
- FSM states: IDLE, A_SEND, WAIT_D, RSP.
- IDLE:
  - req_ready=1. On req_valid, capture all req_* fields.
  - Alignment check: the address is misaligned if req_addr[log2(TL_STRB_WIDTH)-1:0] != 0.
  - If misaligned: go to RSP with rsp_error=1, rsp_rdata=0, rsp_timeout=0. Nothing is issued on the A channel and the source counter does not advance.
  - If aligned: go to A_SEND.
- A_SEND:
  - a_valid=1 starting the cycle after acceptance. All a_* are registered and stable until the handshake.
  - Opcode selection: read -> Get; write with req_be all ones -> PutFullData; write with any other req_be -> PutPartialData.
  - Field values: a_param=0. a_size=log2(TL_STRB_WIDTH) (3 at default). a_mask = all ones for Get, req_be for Put. a_data = req_wdata for Put, 0 for Get. a_source = source counter.
  - On a_valid && a_ready: drop a_valid the next cycle, increment the source counter modulo 2^TL_SOURCE_WIDTH, clear the timeout counter, go to WAIT_D.
- WAIT_D:
  - d_ready=1 only in this state. The timeout counter increments every cycle.
  - On d_valid: go to RSP, registering the response.
  - Expected opcode is AccessAckData for Get, AccessAck for Put.
  - rsp_error = d_error OR (d_source != issued source) OR (d_opcode != expected opcode).
  - rsp_rdata = d_data only for an error-free Get; otherwise 0.
  - If the counter reaches TIMEOUT_CYCLES-1 with no d_valid: go to RSP with rsp_error=1, rsp_timeout=1.
  - If d_valid arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1, the response wins.
- RSP:
  - rsp_valid=1, with outputs held until rsp_ready.
  - On handshake: go to IDLE, rsp_valid=0 next cycle, rsp_error and rsp_timeout cleared.
- Latency: request accept (cycle 0) -> a_valid at cycle 1. D handshake at cycle k -> rsp_valid at cycle k+1. req_ready returns the cycle after the rsp handshake.
- d_valid outside WAIT_D is ignored: d_ready=0 there and no state changes.
- req_valid outside IDLE is ignored: req_ready=0 there.
- Reset mid-transaction returns to IDLE immediately. Any in-flight TL-UL response is abandoned.

Test Plan:
- Aligned read, addr 0x40, slave responds AccessAckData, d_source=0, d_data=0xDEAD_BEEF_0000_0001 -> a_opcode=4, a_mask=0xFF, a_source=0, a_size=3; rsp_rdata=0xDEAD_BEEF_0000_0001, rsp_error=0.
- Write with be=0xFF then be=0x0F to addr 0x08 -> first a_opcode=0 with a_source=0, second a_opcode=1 with a_mask=0x0F and a_source=1; both complete with rsp_error=0 on AccessAck.
- Misaligned read, addr 0x43 -> a_valid never asserted; rsp_valid=1 with rsp_error=1 one cycle after accept; next legal request uses a_source=0.
- Slave returns d_source=5 when 2 was issued, or AccessAck for a Get -> rsp_error=1, rsp_rdata=0.
- TIMEOUT_CYCLES=8, slave holds d_valid=0 -> rsp_valid at 8 cycles after entering WAIT_D; rsp_error=1, rsp_timeout=1; a later d_valid in IDLE is ignored.
- a_ready held low for 5 cycles, rsp_ready held low for 3 cycles, rst pulsed low during WAIT_D -> a_* fields stable throughout; rsp fields held; after reset all outputs are 0 and req_ready=1.
